// File: rtl/axi_aw_w_scheduler_pkg.sv
// axi_aw_w_scheduler_pkg: shared types for the AW/W write scheduler
package axi_aw_w_scheduler_pkg;
  typedef enum logic {AW_ARB, AW_HOLD} aw_state_e;
endpackage

// File: rtl/axi_sched_idx_fifo.sv
// axi_sched_idx_fifo: synchronous FIFO holding granted port indices in AW order
module axi_sched_idx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);
  localparam int unsigned PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign head_o  = mem_q[rd_q];
  always_comb begin
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    wr_d    = do_push ? inc(wr_q) : wr_q;
    rd_d    = do_pop ? inc(rd_q) : rd_q;
    cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
  assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_o))
    else $error("idx fifo pushed while full");
endmodule

// File: rtl/axi_aw_w_scheduler.sv
// axi_aw_w_scheduler: round-robin AW arbiter with in-order W steering and outstanding-write limit
module axi_aw_w_scheduler
  import axi_aw_w_scheduler_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned MAX_W_TXNS = 8,
  localparam int unsigned IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_PORTS-1:0] slv_aw_valid_i,
  output logic [NUM_PORTS-1:0] slv_aw_ready_o,
  input  logic [NUM_PORTS-1:0] slv_w_valid_i,
  input  logic [NUM_PORTS-1:0] slv_w_last_i,
  output logic [NUM_PORTS-1:0] slv_w_ready_o,
  output logic                 mst_aw_valid_o,
  input  logic                 mst_aw_ready_i,
  output logic [IDX_W-1:0]     mst_aw_sel_o,
  output logic                 mst_w_valid_o,
  output logic                 mst_w_last_o,
  input  logic                 mst_w_ready_i,
  output logic [IDX_W-1:0]     mst_w_sel_o,
  input  logic                 mst_b_valid_i,
  input  logic                 mst_b_ready_i
);
  localparam int unsigned CNT_W = $clog2(MAX_W_TXNS + 1);
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [CNT_W-1:0] cnt_t;
  aw_state_e state_q, state_d;
  idx_t rr_q, rr_d, hold_q, hold_d;
  cnt_t cnt_q, cnt_d;
  logic eligible, aw_valid, aw_hs, b_hs, w_active, w_valid, w_last, w_pop;
  logic fifo_full, fifo_empty;
  idx_t aw_sel, w_sel, fifo_head;
  logic [NUM_PORTS-1:0] aw_ready_v, w_ready_v;
  function automatic idx_t rr_pick(input logic [NUM_PORTS-1:0] req, input idx_t ptr);
    idx_t g;
    int   k;
    g = ptr;
    for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % int'(NUM_PORTS);
      if (req[k]) g = idx_t'(k);
    end
    return g;
  endfunction
  always_comb begin
    eligible   = (cnt_q < CNT_W'(MAX_W_TXNS)) && !fifo_full && |slv_aw_valid_i;
    aw_valid   = (state_q == AW_HOLD) || eligible;
    aw_sel     = state_q == AW_HOLD ? hold_q : eligible ? rr_pick(slv_aw_valid_i, rr_q) : '0;
    aw_hs      = aw_valid && mst_aw_ready_i;
    b_hs       = mst_b_valid_i && mst_b_ready_i;
    state_d    = (aw_valid && !mst_aw_ready_i) ? AW_HOLD : AW_ARB;
    hold_d     = aw_valid ? aw_sel : hold_q;
    rr_d       = aw_hs ? (aw_sel == idx_t'(NUM_PORTS - 1) ? '0 : aw_sel + idx_t'(1)) : rr_q;
    cnt_d      = cnt_q + CNT_W'(aw_hs) - CNT_W'(b_hs && (aw_hs || cnt_q != '0));
    aw_ready_v = '0;
    aw_ready_v[aw_sel] = aw_hs;
    w_active   = !fifo_empty;
    w_sel      = w_active ? fifo_head : '0;
    w_valid    = w_active && slv_w_valid_i[w_sel];
    w_last     = w_active && slv_w_last_i[w_sel];
    w_ready_v  = '0;
    w_ready_v[w_sel] = w_active && mst_w_ready_i;
    w_pop      = w_valid && w_last && mst_w_ready_i;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= AW_ARB;
      rr_q    <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end
  axi_sched_idx_fifo #(
    .DEPTH (MAX_W_TXNS),
    .WIDTH (IDX_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (aw_hs),
    .data_i  (aw_sel),
    .pop_i   (w_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );
  assign slv_aw_ready_o = rst_i ? '0 : aw_ready_v;
  assign slv_w_ready_o  = rst_i ? '0 : w_ready_v;
  assign mst_aw_valid_o = !rst_i && aw_valid;
  assign mst_aw_sel_o   = rst_i ? '0 : aw_sel;
  assign mst_w_valid_o  = !rst_i && w_valid;
  assign mst_w_last_o   = !rst_i && w_last;
  assign mst_w_sel_o    = rst_i ? '0 : w_sel;
  assert property (@(posedge clk_i) disable iff (rst_i)
    mst_aw_valid_o && !mst_aw_ready_i |=> mst_aw_valid_o && $stable(mst_aw_sel_o))
    else $error("AW valid/select changed while stalled");
  assert property (@(posedge clk_i) disable iff (rst_i)
    !(mst_b_valid_i && mst_b_ready_i && cnt_q == '0))
    else $error("B handshake with no outstanding write");
endmodule
